// File: rtl/gpu_lane_pkg.sv
// Shared types for the mini-GPU execution lane: opcodes and lane FSM states.
package gpu_lane_pkg;

    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        OPC_ADD  = 3'b000,
        OPC_SUB  = 3'b001,
        OPC_MUL  = 3'b010,
        OPC_UDIV = 3'b011,
        OPC_FADD = 3'b100,
        OPC_FSUB = 3'b101,
        OPC_SHL  = 3'b110,
        OPC_HALT = OP_HALT
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DIV  = 2'd3
    } lane_state_t;

endpackage

// File: rtl/gpu_add.sv
// Plain integer adder with carry-in, shared by ADD and SUB (a + ~b + 1).
module gpu_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    assign sum = a + b + W'(cin);

endmodule

// File: rtl/gpu_fl32_add.sv
// Single-precision adder: denormals flush to zero, round-to-nearest-even,
// overflow saturates to infinity.
module gpu_fl32_add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic [31:0]       big, sml;
    logic [7:0]        e_diff;
    logic [26:0]       m_big, m_sml, m_sml_sh, m_norm;
    logic [27:0]       m_sum;
    logic [24:0]       m_rnd;
    logic signed [9:0] e_norm;
    logic              round_up;
    int                lz;

    // NOTE: every variable gets a default at the top of a combinational block,
    // so no path can leave it holding its old value and infer a latch.
    always_comb begin
        big      = (a[30:0] >= b[30:0]) ? a : b;
        sml      = (a[30:0] >= b[30:0]) ? b : a;
        m_big    = (big[30:23] != 8'd0) ? {1'b1, big[22:0], 3'b000} : 27'd0;
        m_sml    = (sml[30:23] != 8'd0) ? {1'b1, sml[22:0], 3'b000} : 27'd0;
        e_diff   = big[30:23] - sml[30:23];
        e_norm   = $signed({2'b00, big[30:23]});
        lz       = 27;
        m_norm   = 27'd0;
        m_sml_sh = 27'd0;

        // Alignment keeps a sticky bit so rounding still sees discarded ones.
        if (e_diff >= 8'd27) begin
            m_sml_sh = {26'd0, |m_sml};
        end else begin
            m_sml_sh    = m_sml >> e_diff;
            m_sml_sh[0] = m_sml_sh[0] | (|(m_sml & ((27'd1 << e_diff) - 27'd1)));
        end

        if (big[31] == sml[31]) m_sum = {1'b0, m_big} + {1'b0, m_sml_sh};
        else                    m_sum = {1'b0, m_big} - {1'b0, m_sml_sh};

        if (m_sum[27]) begin
            m_norm    = m_sum[27:1];
            m_norm[0] = m_sum[1] | m_sum[0];
            e_norm    = e_norm + 10'sd1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (m_sum[i]) lz = 26 - i;
            end
            m_norm = m_sum[26:0] << lz;
            e_norm = e_norm - $signed(10'(lz));
        end

        round_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
        m_rnd    = {1'b0, m_norm[26:3]} + 25'(round_up);
        if (m_rnd[24]) begin
            m_rnd  = m_rnd >> 1;
            e_norm = e_norm + 10'sd1;
        end

        if (m_rnd == 25'd0)          sum = 32'd0;
        else if (e_norm >= 10'sd255) sum = {big[31], 8'hFF, 23'd0};
        else if (e_norm <= 10'sd0)   sum = {big[31], 31'd0};
        else                         sum = {big[31], e_norm[7:0], m_rnd[22:0]};
    end

endmodule

// File: rtl/gpu_seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle over DATA_W cycles.
// done/quotient are valid combinationally during the last iteration cycle.
module gpu_seq_udiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] rem, quo, dvs, rem_nxt, quo_nxt;
    logic [DATA_W:0]   rem_sh, diff;
    logic [CNT_W-1:0]  cnt;

    // quo starts as the dividend and shifts quotient bits in from the right.
    always_comb begin
        rem_sh  = {rem, quo[DATA_W-1]};
        diff    = rem_sh - {1'b0, dvs};
        rem_nxt = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
        quo_nxt = {quo[DATA_W-2:0], ~diff[DATA_W]};
    end

    assign done     = busy && (cnt == CNT_W'(DATA_W - 1));
    assign quotient = quo_nxt;

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            rem  <= '0;
            quo  <= dividend;
            dvs  <= divisor;
        end else if (busy) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/gpu_exec_lane.sv
// Per-thread execution lane: streamed register load, then a valid/ready
// instruction stream with single-cycle ops and an iterative divider.
module gpu_exec_lane
    import gpu_lane_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_IDX_W = $clog2(NUM_REGS),
    parameter int SHAMT_W   = 6,
    parameter bit REG0_ZERO = 1'b0,
    parameter bit FP_EN     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          start_pc,
    output logic [31:0]          cur_pc,
    input  logic                 load_valid,
    input  logic [DATA_W-1:0]    load_data,
    output logic                 load_ready,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           opcode,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [SHAMT_W-1:0]   shamt,
    output logic                 res_valid,
    output logic [DATA_W-1:0]    res_data,
    output logic [REG_IDX_W-1:0] res_rd,
    output logic                 illegal,
    output logic                 thread_complete
);

    lane_state_t          state, state_nxt;
    opcode_t              op;
    logic [DATA_W-1:0]    regs [NUM_REGS];
    logic [REG_IDX_W-1:0] load_cnt, div_rd;
    logic [DATA_W-1:0]    op_a, op_b, add_b, add_sum, mul_res, shl_res, fp_res, exec_res, div_q;
    logic                 add_cin, exec_wr, exec_ill, accept, beat, load_last;
    logic                 div_start, div_busy, div_done;

    function automatic logic writable(input logic [REG_IDX_W-1:0] idx);
        return !(REG0_ZERO && idx == '0);
    endfunction

    assign op        = opcode_t'(opcode);
    assign op_a      = (REG0_ZERO && rs1 == '0) ? '0 : regs[rs1];
    assign op_b      = (REG0_ZERO && rs2 == '0) ? '0 : regs[rs2];
    assign accept    = instr_valid && instr_ready;
    assign beat      = load_valid && load_ready;
    assign load_last = (load_cnt == REG_IDX_W'(NUM_REGS - 1));
    assign div_start = accept && (op == OPC_UDIV) && (op_b != '0);

    assign add_cin = (op == OPC_SUB);
    assign add_b   = (op == OPC_SUB) ? ~op_b : op_b;
    assign mul_res = op_a * op_b;
    assign shl_res = (int'(shamt) >= DATA_W) ? '0 : (op_a << shamt);

    gpu_add #(.W(DATA_W)) u_add (
        .a  (op_a),
        .b  (add_b),
        .cin(add_cin),
        .sum(add_sum)
    );

    gpu_seq_udiv #(.DATA_W(DATA_W)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (div_start),
        .dividend(op_a),
        .divisor (op_b),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_q)
    );

    generate
        if (FP_EN) begin : g_fp
            if (DATA_W != 32) begin : g_bad_width
                $error("gpu_exec_lane: FP_EN=1 requires DATA_W==32");
            end else begin : g_fl32
                gpu_fl32_add u_fl32 (
                    .a  (op_a[31:0]),
                    .b  ({op_b[31] ^ (op == OPC_FSUB), op_b[30:0]}),
                    .sum(fp_res[31:0])
                );
            end
        end else begin : g_no_fp
            assign fp_res = '0;
        end
    endgenerate

    always_comb begin
        exec_res = '0;
        exec_wr  = 1'b0;
        exec_ill = 1'b0;
        case (op)
            OPC_ADD, OPC_SUB: begin exec_res = add_sum; exec_wr = 1'b1; end
            OPC_MUL:          begin exec_res = mul_res; exec_wr = 1'b1; end
            OPC_SHL:          begin exec_res = shl_res; exec_wr = 1'b1; end
            OPC_UDIV: begin
                // Divide by zero answers immediately; otherwise the divider owns it.
                if (op_b == '0) begin exec_res = '1; exec_wr = 1'b1; end
            end
            OPC_FADD, OPC_FSUB: begin
                if (FP_EN) begin exec_res = fp_res; exec_wr = 1'b1; end
                else       exec_ill = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: if (beat && load_last) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (accept && opcode == OP_HALT) state_nxt = ST_IDLE;
                else if (div_start)              state_nxt = ST_DIV;
            end
            ST_DIV:  if (div_done) state_nxt = ST_EXEC;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready      = 1'b0;
        instr_ready     = 1'b0;
        thread_complete = 1'b0;
        case (state)
            ST_IDLE: thread_complete = 1'b1;
            ST_LOAD: load_ready      = 1'b1;
            ST_EXEC: instr_ready     = !div_busy;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is deliberately reset because software
            // relies on unloaded registers reading 0 after reset.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            cur_pc    <= '0;
            load_cnt  <= '0;
            div_rd    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            illegal   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_pc   <= start_pc;
                        load_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        if (writable(load_cnt)) regs[load_cnt] <= load_data;
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (accept) begin
                        if (exec_wr) begin
                            if (writable(rd)) regs[rd] <= exec_res;
                            res_valid <= 1'b1;
                            res_data  <= exec_res;
                            res_rd    <= rd;
                        end
                        illegal <= exec_ill;
                        if (div_start) div_rd <= rd;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        if (writable(div_rd)) regs[div_rd] <= div_q;
                        res_valid <= 1'b1;
                        res_data  <= div_q;
                        res_rd    <= div_rd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_exec_lane.sv
// Directed bench: a default 32-bit lane plus a 16-bit, r0-zero, no-FP lane.
module tb_gpu_exec_lane;
    import gpu_lane_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start, load_valid, load_ready, instr_valid, instr_ready;
    logic [31:0] start_pc, cur_pc, load_data, res_data;
    logic [2:0]  opcode;
    logic [4:0]  rs1, rs2, rd, res_rd;
    logic [5:0]  shamt;
    logic        res_valid, illegal, thread_complete;

    logic        s_start, s_load_valid, s_load_ready, s_instr_valid, s_instr_ready;
    logic [31:0] s_start_pc, s_cur_pc;
    logic [15:0] s_load_data, s_res_data;
    logic [2:0]  s_opcode;
    logic [1:0]  s_rs1, s_rs2, s_rd, s_res_rd;
    logic [5:0]  s_shamt;
    logic        s_res_valid, s_illegal, s_thread_complete;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] vals [32];
    logic [15:0] s_vals [4];

    gpu_exec_lane u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .cur_pc(cur_pc),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .shamt(shamt),
        .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .illegal(illegal), .thread_complete(thread_complete)
    );

    gpu_exec_lane #(.DATA_W(16), .NUM_REGS(4), .REG0_ZERO(1'b1), .FP_EN(1'b0)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .start_pc(s_start_pc), .cur_pc(s_cur_pc),
        .load_valid(s_load_valid), .load_data(s_load_data), .load_ready(s_load_ready),
        .instr_valid(s_instr_valid), .instr_ready(s_instr_ready), .opcode(s_opcode),
        .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .shamt(s_shamt),
        .res_valid(s_res_valid), .res_data(s_res_data), .res_rd(s_res_rd),
        .illegal(s_illegal), .thread_complete(s_thread_complete)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- 32-bit lane helpers ----------------
    task automatic m_start(input logic [31:0] pc);
        start_pc = pc;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic m_load();
        int n;
        for (int i = 0; i < 32; i++) begin
            n          = 0;
            load_valid = 1'b1;
            load_data  = vals[i];
            while (!load_ready && n < 64) begin step(); n++; end
            if (!load_ready) check("m_load_ready_timeout", 64'(load_ready), 64'd1);
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic m_drive(input opcode_t op, input int a, input int b, input int d, input int sh);
        int n;
        n           = 0;
        opcode      = op;
        rs1         = 5'(a);
        rs2         = 5'(b);
        rd          = 5'(d);
        shamt       = 6'(sh);
        instr_valid = 1'b1;
        while (!instr_ready && n < 64) begin step(); n++; end
        if (!instr_ready) check("m_instr_ready_timeout", 64'(instr_ready), 64'd1);
        step();
    endtask

    task automatic m_single(input string tag, input opcode_t op, input int a, input int b,
                            input int d, input int sh, input logic [31:0] exp);
        m_drive(op, a, b, d, sh);
        instr_valid = 1'b0;
        check({tag, "_valid"}, 64'(res_valid), 64'd1);
        check({tag, "_data"}, 64'(res_data), 64'(exp));
        check({tag, "_rd"}, 64'(res_rd), 64'(d));
    endtask

    // ---------------- 16-bit lane helpers ----------------
    task automatic s_load();
        int n;
        for (int i = 0; i < 4; i++) begin
            n            = 0;
            s_load_valid = 1'b1;
            s_load_data  = s_vals[i];
            while (!s_load_ready && n < 64) begin step(); n++; end
            if (!s_load_ready) check("s_load_ready_timeout", 64'(s_load_ready), 64'd1);
            step();
        end
        s_load_valid = 1'b0;
    endtask

    task automatic s_drive(input opcode_t op, input int a, input int b, input int d, input int sh);
        int n;
        n             = 0;
        s_opcode      = op;
        s_rs1         = 2'(a);
        s_rs2         = 2'(b);
        s_rd          = 2'(d);
        s_shamt       = 6'(sh);
        s_instr_valid = 1'b1;
        while (!s_instr_ready && n < 64) begin step(); n++; end
        if (!s_instr_ready) check("s_instr_ready_timeout", 64'(s_instr_ready), 64'd1);
        step();
        s_instr_valid = 1'b0;
    endtask

    task automatic s_single(input string tag, input opcode_t op, input int a, input int b,
                            input int d, input int sh, input logic [15:0] exp);
        s_drive(op, a, b, d, sh);
        check({tag, "_valid"}, 64'(s_res_valid), 64'd1);
        check({tag, "_data"}, 64'(s_res_data), 64'(exp));
        check({tag, "_rd"}, 64'(s_res_rd), 64'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_cycles, pulses;
        rst_n = 1'b0;
        start = 1'b0; start_pc = '0; load_valid = 1'b0; load_data = '0;
        instr_valid = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0; shamt = '0;
        s_start = 1'b0; s_start_pc = '0; s_load_valid = 1'b0; s_load_data = '0;
        s_instr_valid = 1'b0; s_opcode = '0; s_rs1 = '0; s_rs2 = '0; s_rd = '0; s_shamt = '0;
        #1;
        // Reset state
        check("rst_thread_complete", 64'(thread_complete), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_load_ready", 64'(load_ready), 64'd0);
        check("rst_instr_ready", 64'(instr_ready), 64'd0);
        check("rst_cur_pc", 64'(cur_pc), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_rd", 64'(res_rd), 64'd0);
        check("rst_s_thread_complete", 64'(s_thread_complete), 64'd1);
        step(); step();
        rst_n = 1'b1;
        step();

        // 1: start, load, ADD
        vals = '{default: 32'd0};
        vals[1] = 32'd7; vals[2] = 32'd5; vals[10] = 32'd100; vals[11] = 32'd7;
        vals[12] = 32'h3FC0_0000; vals[13] = 32'h4010_0000;
        m_start(32'h100);
        check("start_load_ready", 64'(load_ready), 64'd1);
        check("start_thread_complete", 64'(thread_complete), 64'd0);
        m_load();
        check("exec_instr_ready", 64'(instr_ready), 64'd1);
        m_single("add", OPC_ADD, 1, 2, 3, 0, 32'd12);
        check("cur_pc", 64'(cur_pc), 64'h100);

        // 2: back-to-back dependent ops
        m_drive(OPC_SUB, 1, 2, 4, 0);
        check("sub1_data", 64'(res_data), 64'd2);
        m_drive(OPC_SUB, 2, 1, 5, 0);
        check("sub2_data", 64'(res_data), 64'hFFFF_FFFE);
        m_drive(OPC_ADD, 4, 5, 6, 0);
        check("dep_add_valid", 64'(res_valid), 64'd1);
        check("dep_add_data", 64'(res_data), 64'd0);
        instr_valid = 1'b0;
        step();
        check("res_valid_one_cycle", 64'(res_valid), 64'd0);

        // 3: UDIV 100/7 with an ADD held valid behind it
        m_drive(OPC_UDIV, 10, 11, 7, 0);
        opcode = OPC_ADD; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd8;
        lat = 1; busy_cycles = 0;
        while (!res_valid && lat < 100) begin
            if (!instr_ready) busy_cycles++;
            step();
            lat++;
        end
        check("udiv_latency", 64'(lat), 64'd33);
        check("udiv_busy_cycles", 64'(busy_cycles), 64'd32);
        check("udiv_data", 64'(res_data), 64'd14);
        check("udiv_rd", 64'(res_rd), 64'd7);
        step();
        instr_valid = 1'b0;
        check("held_add_valid", 64'(res_valid), 64'd1);
        check("held_add_data", 64'(res_data), 64'd12);
        check("held_add_rd", 64'(res_rd), 64'd8);
        m_single("udiv_writeback", OPC_ADD, 7, 0, 9, 0, 32'd14);
        m_single("udiv_by_zero", OPC_UDIV, 1, 0, 9, 0, 32'hFFFF_FFFF);

        // 4: FP, shifts, multiply
        m_single("fadd", OPC_FADD, 12, 13, 14, 0, 32'h4070_0000);
        check("fadd_not_illegal", 64'(illegal), 64'd0);
        m_single("fsub", OPC_FSUB, 12, 13, 15, 0, 32'hBF40_0000);
        m_single("shl3", OPC_SHL, 1, 0, 16, 3, 32'd56);
        m_single("shl31", OPC_SHL, 1, 0, 17, 31, 32'h8000_0000);
        m_single("shl40", OPC_SHL, 1, 0, 18, 40, 32'd0);
        m_single("mul", OPC_MUL, 10, 11, 19, 0, 32'd700);
        m_single("mul_wrap", OPC_MUL, 5, 1, 20, 0, 32'hFFFF_FFF2);

        // 5: 16-bit lane, hardwired r0, no FP
        s_vals[0] = 16'hDEAD; s_vals[1] = 16'd3; s_vals[2] = 16'd4; s_vals[3] = 16'd0;
        s_start_pc = 32'h40;
        s_start    = 1'b1;
        step();
        s_start = 1'b0;
        s_load();
        s_single("s_add_r0", OPC_ADD, 1, 2, 0, 0, 16'd7);
        s_single("s_r0_reads_zero", OPC_ADD, 0, 1, 3, 0, 16'd3);
        s_single("s_sub_wrap", OPC_SUB, 0, 1, 2, 0, 16'hFFFD);
        s_single("s_shl15", OPC_SHL, 1, 0, 3, 15, 16'h8000);
        s_single("s_shl16", OPC_SHL, 1, 0, 3, 16, 16'd0);
        s_drive(OPC_FADD, 1, 2, 2, 0);
        check("s_fadd_illegal", 64'(s_illegal), 64'd1);
        check("s_fadd_no_result", 64'(s_res_valid), 64'd0);
        step();
        check("s_illegal_one_cycle", 64'(s_illegal), 64'd0);
        s_single("s_fadd_no_write", OPC_ADD, 2, 0, 3, 0, 16'hFFFD);
        check("s_cur_pc", 64'(s_cur_pc), 64'h40);

        // 6: HALT, restart, start ignored in EXEC, reset mid-divide
        m_drive(OPC_HALT, 0, 0, 0, 0);
        instr_valid = 1'b0;
        check("halt_thread_complete", 64'(thread_complete), 64'd1);
        check("halt_instr_ready", 64'(instr_ready), 64'd0);
        check("halt_no_result", 64'(res_valid), 64'd0);
        vals[1] = 32'd20; vals[2] = 32'd22;
        m_start(32'h200);
        m_load();
        m_single("reload_add", OPC_ADD, 1, 2, 3, 0, 32'd42);
        m_start(32'h300);
        check("start_ignored_pc", 64'(cur_pc), 64'h200);
        check("start_ignored_ready", 64'(instr_ready), 64'd1);
        m_drive(OPC_UDIV, 10, 11, 7, 0);
        instr_valid = 1'b0;
        repeat (9) step();
        check("mid_div_busy", 64'(instr_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_div_rst_res_valid", 64'(res_valid), 64'd0);
        check("mid_div_rst_thread_complete", 64'(thread_complete), 64'd1);
        check("mid_div_rst_instr_ready", 64'(instr_ready), 64'd0);
        check("mid_div_rst_cur_pc", 64'(cur_pc), 64'd0);
        check("mid_div_rst_res_data", 64'(res_data), 64'd0);
        step(); step();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (res_valid) pulses++;
        end
        check("post_rst_no_result", 64'(pulses), 64'd0);
        check("post_rst_idle", 64'(thread_complete), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_exec_lane.md
Name: gpu_exec_lane

Overview:
Parametrised next-generation per-thread execution lane for the mini-GPU core. It holds a private register file of NUM_REGS entries of DATA_W bits, filled by a streamed initial-load handshake. It then executes a stream of 3-bit-opcode instructions under a valid/ready handshake and returns results on a single-cycle result pulse. Compared with the current functional unit, it adds configurable width and depth, an iterative multi-cycle divider, a shift op, an optional hardwired-zero r0, an explicit start pulse, and explicit back-pressure.

Parameters:
DATA_W, 32, datapath and register width
NUM_REGS, 32, register-file depth (power of two, >=2)
REG_IDX_W, $clog2(NUM_REGS), register index width (derived, do not override)
SHAMT_W, 6, shift-amount width
REG0_ZERO, 0, 1 = r0 reads 0 and ignores every write and load beat
FP_EN, 1, 1 = FADD/FSUB use fl32; requires DATA_W==32, otherwise an elaboration error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a new thread; honoured only in IDLE
start_pc  in  32  thread PC, latched on an accepted start
cur_pc  out  32  latched start_pc
load_valid  in  1  initial register beat valid
load_data  in  DATA_W  initial register value
load_ready  out  1  lane accepts a load beat
instr_valid  in  1  instruction valid
instr_ready  out  1  lane accepts an instruction
opcode  in  3  000 ADD, 001 SUB, 010 MUL, 011 UDIV, 100 FADD, 101 FSUB, 110 SHL, 111 HALT
rs1  in  REG_IDX_W  source register 1
rs2  in  REG_IDX_W  source register 2
rd  in  REG_IDX_W  destination register
shamt  in  SHAMT_W  shift amount for SHL
res_valid  out  1  one-cycle result pulse
res_data  out  DATA_W  result value
res_rd  out  REG_IDX_W  destination of the result
illegal  out  1  one-cycle pulse on FADD/FSUB when FP_EN=0
thread_complete  out  1  lane idle / thread finished

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE; all registers are 0.
  - cur_pc, res_data and res_rd are 0.
  - res_valid, illegal, load_ready and instr_ready are 0.
  - thread_complete is 1.
  - Reset mid-load or mid-divide aborts the operation with no result.
- States: IDLE, LOAD, EXEC, DIV.
- IDLE:
  - thread_complete=1.
  - start → LOAD at the next edge; latch start_pc, clear the load counter, thread_complete goes to 0.
- LOAD:
  - load_ready=1.
  - Each accepted beat (load_valid & load_ready) writes reg[cnt] and increments cnt.
  - The beat accepted with cnt==NUM_REGS-1 moves the state to EXEC.
  - With REG0_ZERO=1 the beat for r0 is consumed but discarded.
  - start is ignored.
- EXEC:
  - instr_ready=1. Operands are read combinationally from the register file.
  - For single-cycle ops, reg[rd] is written at the accept edge, and res_valid/res_data/res_rd are registered at that edge, giving latency 1.
  - Back-to-back dependent instructions see the new value.
  - Op rules:
    - ADD: rs1+rs2 mod 2^DATA_W, via the existing add block with cin=0.
    - SUB: rs1 + ~rs2 with cin=1.
    - MUL: low DATA_W bits of the product.
    - SHL: rs1 << shamt; shamt >= DATA_W gives 0.
    - FADD/FSUB: fl32, with FSUB inverting rs2 bit 31. With FP_EN=0: no write, res_valid=0, illegal=1 for one cycle.
    - UDIV with rs2==0: result all-ones, latency 1.
    - UDIV with rs2!=0: latch the operands and rd, go to DIV.
    - HALT: no write, no res_valid; go to IDLE, and thread_complete=1 from the next cycle.
  - Writes to r0 are dropped when REG0_ZERO=1; res_valid still pulses with the computed value.
- DIV:
  - instr_ready=0. Restoring division runs one quotient bit per cycle over DATA_W cycles.
  - At the final iteration edge: write the quotient to reg[rd], pulse res_valid, return to EXEC.
  - Accept edge to res_valid is DATA_W+1 cycles.
  - An instruction held valid during DIV is accepted in the first EXEC cycle.
- start is ignored outside IDLE. res_valid has no back-pressure.

Decomposition:
- Package gpu_lane_pkg holds:
  - the opcode_t enum (8 codes above);
  - the lane_state_t enum;
  - the constant OP_HALT = 3'b111.
- Sub-module gpu_seq_udiv: parametrised by DATA_W, with ports start, dividend, divisor, busy, done, quotient; takes DATA_W cycles.
- Reuses the existing add and fl32 blocks.

Test Plan:
1. Start with start_pc=0x100 and load r1=7, r2=5, rest 0. Then ADD rd=3. Expect res_valid one cycle after accept, res_data=12, res_rd=3, cur_pc=0x100.
2. Issue SUB rd=4 (r1−r2), then back-to-back SUB rd=5 (r2−r1), then ADD rd=6 (r4+r5). Expect 2, then 0xFFFFFFFE, then 0 on consecutive cycles.
3. Run UDIV 100/7. Expect instr_ready low for 32 cycles and res_data=14 at accept+33. Run UDIV by r0=0. Expect 0xFFFFFFFF at latency 1.
4. Run FADD 0x3FC00000+0x40100000. Expect 0x40700000. Run FSUB of the same operands. Expect 0xBF400000. Run SHL r1 by 3. Expect 56. Run SHL with shamt=40. Expect 0.
5. With REG0_ZERO=1: load 0xDEAD into r0, then ADD rd=0. r0 still reads 0. With FP_EN=0 and DATA_W=16: issue FADD. Expect illegal pulse and no res_valid.
6. Issue HALT. Expect thread_complete=1 and instr_ready=0 next cycle; a new start reloads the registers. Drive rst_n low at divide cycle 10. Expect immediate reset values and no res_valid.
